tick_rr_scheduler: RTL and testbench

- Periodic slot scheduler: a mod-PERIOD counter generates a one-cycle tick; each tick slot is granted to one of N requesters in round-robin order.
- Sequences and shares the periodic-pulse datapath used by the term-project FSMs, so several consumers can take turns on one divided-clock event stream.
- All outputs are registered. There is no combinational path from req to grant.

---
 rtl/tick_rr_scheduler.sv | 103 ++++++++++
 tb/tb_tick_rr_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tick_rr_scheduler.sv
// tick_rr_scheduler
//   Periodic slot scheduler. A mod-PERIOD counter marks a slot boundary
//   every PERIOD enabled cycles. Each boundary produces a one-cycle tick and
//   hands that slot to one requester, chosen in round-robin order.
//   All outputs are registered, so there is no combinational path from req
//   to grant.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   en       count enable; the counter and ticks advance only while high
//   clr      synchronous clear of the counter and RR pointer (wins over en)
//   req      request vector, bit i = requester i wants the next slot
//   tick     one-cycle pulse marking a slot boundary
//   grant    one-hot grant, nonzero only in the tick cycle
//   gnt_id   index of the most recent winner; holds between grants
//   gnt_vld  high from the first grant after reset/clr onward
module tick_rr_scheduler #(
  parameter int N      = 4,
  parameter int PERIOD = 3,
  parameter int CW     = 2,
  parameter int IW     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [N-1:0]  req,
  output logic          tick,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_vld
);

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(N - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr;

  logic          win_found;
  logic [IW-1:0] win_id;
  logic [IW-1:0] ptr_next;

  // Round-robin search from ptr upward. The first pass covers ptr..N-1; the
  // second pass (only if nothing was found) wraps around to 0..ptr-1.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[i] && (IW'(i) >= ptr)) begin
        win_found = 1'b1;
        win_id    = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_id    = IW'(i);
      end
    end
  end

  assign ptr_next = (win_id == ID_LAST) ? '0 : win_id + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      ptr     <= '0;
      tick    <= 1'b0;
      grant   <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
    end else if (clr) begin
      // gnt_id deliberately holds across clr; only the validity flag drops.
      cnt     <= '0;
      ptr     <= '0;
      tick    <= 1'b0;
      grant   <= '0;
      gnt_vld <= 1'b0;
    end else if (!en) begin
      tick  <= 1'b0;
      grant <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt   <= cnt + 1'b1;
      tick  <= 1'b0;
      grant <= '0;
    end else begin
      // Slot edge: the tick always fires; an empty slot is simply lost.
      cnt  <= '0;
      tick <= 1'b1;
      if (win_found) begin
        grant   <= N'(1) << win_id;
        gnt_id  <= win_id;
        gnt_vld <= 1'b1;
        ptr     <= ptr_next;
      end else begin
        grant <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tick_rr_scheduler.sv
// Directed bench for tick_rr_scheduler (N=4, PERIOD=3). Inputs change and
// outputs are sampled on the falling edge, away from the active edge.
module tb_tick_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [3:0] req;
  logic       tick;
  logic [3:0] grant;
  logic [1:0] gnt_id;
  logic       gnt_vld;

  int vectors    = 0;
  int miscompares = 0;

  tick_rr_scheduler #(.N(4), .PERIOD(3), .CW(2), .IW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .req     (req),
    .tick    (tick),
    .grant   (grant),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full slot from cnt=0: two quiet edges, then the tick edge.
  task automatic slot(input string tag, input logic [3:0] exp_grant, input logic [1:0] exp_id);
    step();
    chk({tag, " pre1 tick"}, 32'(tick), 32'd0);
    step();
    chk({tag, " pre2 tick"}, 32'(tick), 32'd0);
    chk({tag, " pre2 grant"}, 32'(grant), 32'd0);
    step();
    chk({tag, " tick"}, 32'(tick), 32'd1);
    chk({tag, " grant"}, 32'(grant), 32'(exp_grant));
    chk({tag, " gnt_id"}, 32'(gnt_id), 32'(exp_id));
    chk({tag, " gnt_vld"}, 32'(gnt_vld), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
    req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset gnt_id", 32'(gnt_id), 32'd0);
    chk("reset gnt_vld", 32'(gnt_vld), 32'd0);

    // Idle requests: ticks after edges 3, 6, 9, never a grant.
    rst = 1'b1;
    en  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("idle tick e%0d", k), 32'(tick), (k % 3 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("idle grant e%0d", k), 32'(grant), 32'd0);
      chk($sformatf("idle vld e%0d", k), 32'(gnt_vld), 32'd0);
    end
    chk("idle ptr", 32'(dut.ptr), 32'd0);

    // All requesting: strict rotation 0,1,2,3,0.
    req = 4'b1111;
    slot("rr0", 4'b0001, 2'd0);
    slot("rr1", 4'b0010, 2'd1);
    slot("rr2", 4'b0100, 2'd2);
    slot("rr3", 4'b1000, 2'd3);
    slot("rr4", 4'b0001, 2'd0);

    // ptr=1: lone req 2 wins, then wrap search 3,0 picks 0.
    req = 4'b0100;
    slot("single2", 4'b0100, 2'd2);
    req = 4'b0101;
    slot("wrap0", 4'b0001, 2'd0);

    // Pause at cnt=1 for 5 cycles.
    step();
    chk("pause pre tick", 32'(tick), 32'd0);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("pause tick %0d", k), 32'(tick), 32'd0);
      chk($sformatf("pause gnt_id %0d", k), 32'(gnt_id), 32'd0);
    end
    en = 1'b1;
    step();
    chk("resume e1 tick", 32'(tick), 32'd0);
    step();
    chk("resume e2 tick", 32'(tick), 32'd1);
    chk("resume e2 grant", 32'(grant), 32'b0100);
    chk("resume e2 gnt_id", 32'(gnt_id), 32'd2);

    // Async reset mid-slot with cnt=2.
    step();
    step();
    chk("prerst cnt", 32'(dut.cnt), 32'd2);
    req = 4'b1111;
    #2 rst = 1'b0;
    #1;
    chk("async rst tick", 32'(tick), 32'd0);
    chk("async rst grant", 32'(grant), 32'd0);
    chk("async rst vld", 32'(gnt_vld), 32'd0);
    chk("async rst cnt", 32'(dut.cnt), 32'd0);
    chk("async rst gnt_id", 32'(gnt_id), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    slot("post rst", 4'b0001, 2'd0);

    // clr at a slot edge discards that slot and resets ptr.
    step();
    step();
    clr = 1'b1;
    req = 4'b0010;
    step();
    chk("clr tick", 32'(tick), 32'd0);
    chk("clr grant", 32'(grant), 32'd0);
    chk("clr vld", 32'(gnt_vld), 32'd0);
    chk("clr cnt", 32'(dut.cnt), 32'd0);
    chk("clr ptr", 32'(dut.ptr), 32'd0);
    chk("clr gnt_id hold", 32'(gnt_id), 32'd0);
    clr = 1'b0;
    slot("post clr", 4'b0010, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
